// File: rtl/lenet_result_reader.sv
// lenet_result_reader
// Takes one snapshot of the LeNet accelerator's score vector a fixed number of
// edges after a start request. The scores are then streamed one per
// valid/ready transfer, lowest index first, while a running signed argmax is
// kept. The winning class is published with a one-cycle done pulse.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          one-cycle request, sampled only in IDLE
//   output_vector  NUM_CLASSES x BITWIDTH two's-complement scores
//   busy           high whenever the FSM is not in IDLE
//   score_data     currently offered score
//   score_idx      class index of score_data
//   score_valid    score_data/score_idx are valid
//   score_ready    downstream accepts the offered score
//   class_id       argmax index, held until the next final transfer
//   class_score    score at class_id, held until the next final transfer
//   done           one-cycle pulse, class_id/class_score are final
module lenet_result_reader #(
   parameter int unsigned BITWIDTH    = 32,
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [BITWIDTH-1:0] output_vector [NUM_CLASSES-1:0],
   output logic                busy,
   output logic [BITWIDTH-1:0] score_data,
   output logic [3:0]          score_idx,
   output logic                score_valid,
   input  logic                score_ready,
   output logic [3:0]          class_id,
   output logic [BITWIDTH-1:0] class_score,
   output logic                done
);

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   // Reject parameter sets that the 4-bit index/counter cannot represent
   if (LATENCY < 1 || LATENCY > 15 || NUM_CLASSES < 1 || NUM_CLASSES > 16) begin : g_param_chk
      $error("lenet_result_reader: illegal LATENCY or NUM_CLASSES");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [BITWIDTH-1:0] snap_q [NUM_CLASSES];
   logic [BITWIDTH-1:0] max_q;
   logic [IDX_W-1:0]    cls_q;

   logic                busy_q;
   logic [BITWIDTH-1:0] score_data_q;
   logic [IDX_W-1:0]    score_idx_q;
   logic                score_valid_q;
   logic [IDX_W-1:0]    class_id_q;
   logic [BITWIDTH-1:0] class_score_q;
   logic                done_q;

   logic                xfer_c;
   logic                take_c;
   logic [BITWIDTH-1:0] cur_score_c;
   logic [BITWIDTH-1:0] max_d;
   logic [IDX_W-1:0]    cls_d;
   logic [IDX_W-1:0]    idx_d;

   // Running argmax update for the score being transferred; strict compare
   // keeps the lowest index on ties, index 0 always seeds the search.
   always_comb begin
      xfer_c      = 1'b0;
      take_c      = 1'b0;
      cur_score_c = snap_q[idx_q];
      max_d       = max_q;
      cls_d       = cls_q;
      idx_d       = idx_q + IDX_W'(1);
      xfer_c      = score_valid_q & score_ready;
      take_c      = (idx_q == '0) || ($signed(cur_score_c) > $signed(max_q));
      if (take_c) begin
         max_d = cur_score_c;
         cls_d = idx_q;
      end
   end

   // Control FSM with all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         max_q         <= '0;
         cls_q         <= '0;
         for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            snap_q[i] <= '0;
         end
         busy_q        <= 1'b0;
         score_data_q  <= '0;
         score_idx_q   <= '0;
         score_valid_q <= 1'b0;
         class_id_q    <= '0;
         class_score_q <= '0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cnt_q   <= CNT_W'(LATENCY);
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT;
               end
            end

            // Count down the accelerator pipeline; capture on the last count
            ST_WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                     snap_q[i] <= output_vector[i];
                  end
                  idx_q         <= '0;
                  score_idx_q   <= '0;
                  score_data_q  <= output_vector[0];
                  score_valid_q <= 1'b1;
                  state_q       <= ST_STREAM;
               end
            end

            // Offer snap[idx] until accepted; the last transfer publishes the result
            ST_STREAM: begin
               if (xfer_c) begin
                  max_q <= max_d;
                  cls_q <= cls_d;
                  if (idx_q == LAST_IDX) begin
                     class_id_q    <= cls_d;
                     class_score_q <= max_d;
                     score_valid_q <= 1'b0;
                     done_q        <= 1'b1;
                     state_q       <= ST_DONE;
                  end else begin
                     idx_q        <= idx_d;
                     score_idx_q  <= idx_d;
                     score_data_q <= snap_q[idx_d];
                  end
               end
            end

            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign score_data  = score_data_q;
   assign score_idx   = score_idx_q;
   assign score_valid = score_valid_q;
   assign class_id    = class_id_q;
   assign class_score = class_score_q;
   assign done        = done_q;

endmodule

// File: tb/tb_lenet_result_reader.sv
// Directed bench for lenet_result_reader: basic run, backpressure, signed and
// tie argmax, snapshot isolation with ignored starts, mid-stream reset and a
// LATENCY sweep on two extra instances.
module tb_lenet_result_reader;

   localparam int unsigned BW = 32;
   localparam int unsigned NC = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [BW-1:0] ov [NC-1:0];
   logic          score_ready;

   logic          busy, score_valid, done;
   logic [BW-1:0] score_data, class_score;
   logic [3:0]    score_idx, class_id;

   logic          start_sw;
   logic          ready_sw;
   logic          busy1, v1, done1, busy5, v5, done5;
   logic [BW-1:0] d1, cs1, d5, cs5;
   logic [3:0]    i1, ci1, i5, ci5;

   logic [BW-1:0] exp_vec [NC];
   bit   [15:0]   rpat = 16'b1100_1011_0100_1101;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lenet_result_reader #(.BITWIDTH(BW), .NUM_CLASSES(NC), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .start(start), .output_vector(ov),
      .busy(busy), .score_data(score_data), .score_idx(score_idx),
      .score_valid(score_valid), .score_ready(score_ready),
      .class_id(class_id), .class_score(class_score), .done(done));

   lenet_result_reader #(.BITWIDTH(BW), .NUM_CLASSES(NC), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .start(start_sw), .output_vector(ov),
      .busy(busy1), .score_data(d1), .score_idx(i1),
      .score_valid(v1), .score_ready(ready_sw),
      .class_id(ci1), .class_score(cs1), .done(done1));

   lenet_result_reader #(.BITWIDTH(BW), .NUM_CLASSES(NC), .LATENCY(5)) dut_l5 (
      .clk(clk), .reset(reset), .start(start_sw), .output_vector(ov),
      .busy(busy5), .score_data(d5), .score_idx(i5),
      .score_valid(v5), .score_ready(ready_sw),
      .class_id(ci5), .class_score(cs5), .done(done5));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int v [NC]);
      for (int i = 0; i < int'(NC); i++) begin
         ov[i]      = 32'(v[i]);
         exp_vec[i] = 32'(v[i]);
      end
   endtask

   // One full run on the LATENCY=2 instance. n counts edges after the start edge.
   task automatic do_run(input bit bp, input bit iso, input logic [3:0] exp_cls,
                         input logic [31:0] exp_sc);
      int n, nx, fv, dn, bad_stall;
      bit ord_ok;
      logic pv, pr;
      logic [31:0] pd;
      logic [3:0] pi;
      n = 0; nx = 0; fv = -1; dn = -1; bad_stall = 0; ord_ok = 1'b1;
      score_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (dn < 0 && n < 300) begin
         if (score_valid && fv < 0) begin
            fv = n;
            if (iso) for (int i = 0; i < int'(NC); i++) ov[i] = 32'h7FFF_FFFF;
         end
         if (done) begin
            dn = n;
         end else begin
            score_ready = bp ? rpat[n % 16] : 1'b1;
            start = iso && (fv >= 0) && (n == fv + 3);
            pv = score_valid; pr = score_ready; pd = score_data; pi = score_idx;
            tick();
            n++;
            if (pv && pr) begin
               if (nx >= int'(NC) || pi !== 4'(nx) || pd !== exp_vec[nx]) ord_ok = 1'b0;
               nx++;
            end else if (pv) begin
               if (score_valid !== 1'b1 || score_data !== pd || score_idx !== pi)
                  bad_stall++;
            end
         end
      end
      start = 1'b0;
      check("done_seen", 32'(dn >= 0), 32'd1);
      check("first_valid_edge", 32'(fv), 32'd2);
      check("xfer_count", 32'(nx), 32'd10);
      check("xfer_order_data", 32'(ord_ok), 32'd1);
      check("stall_stable", 32'(bad_stall), 32'd0);
      if (!bp) check("done_edge", 32'(dn), 32'd12);
      check("valid_low_in_done", 32'(score_valid), 32'd0);
      check("class_id", 32'(class_id), 32'(exp_cls));
      check("class_score", class_score, exp_sc);
      // DONE cycle: a start here must be ignored
      start = iso;
      tick();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int n, cnt, fv1, fv5, nx1, nx5, dn1, dn5;
      bit ok;
      reset = 1'b1; start = 1'b0; score_ready = 1'b1; start_sw = 1'b0; ready_sw = 1'b1;
      for (int i = 0; i < int'(NC); i++) begin
         ov[i] = '0;
         exp_vec[i] = '0;
      end
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(score_valid), 32'd0);
      check("rst_data", score_data, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_class_id", 32'(class_id), 32'd0);
      reset = 1'b0;
      tick();

      // Basic run
      load('{0, 5, 3, 9, 1, 2, 7, 4, 8, 6});
      do_run(1'b0, 1'b0, 4'd3, 32'd9);

      // Reset between edges while idx 4 is offered
      score_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!(score_valid && score_idx == 4'd4) && n < 30) begin tick(); n++; end
      check("reach_idx4", 32'(score_idx), 32'd4);
      #2 reset = 1'b1;
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_valid", 32'(score_valid), 32'd0);
      check("mrst_data", score_data, 32'd0);
      check("mrst_idx", 32'(score_idx), 32'd0);
      check("mrst_class_id", 32'(class_id), 32'd0);
      check("mrst_class_score", class_score, 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      tick();
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) cnt++;
         tick();
      end
      check("no_done_after_reset", 32'(cnt), 32'd0);
      do_run(1'b0, 1'b0, 4'd3, 32'd9);

      // Backpressure
      do_run(1'b1, 1'b0, 4'd3, 32'd9);

      // Signed scores and ties
      load('{-5, -1, -1, -3, -100, -2, -1, -7, -9, -4});
      do_run(1'b0, 1'b0, 4'd1, 32'hFFFF_FFFF);
      load('{7, 7, 7, 7, 7, 7, 7, 7, 7, 7});
      do_run(1'b1, 1'b0, 4'd0, 32'd7);

      // Snapshot isolation, starts in STREAM/DONE ignored, restart in first IDLE cycle
      load('{0, 5, 3, 9, 1, 2, 7, 4, 8, 6});
      do_run(1'b0, 1'b1, 4'd3, 32'd9);
      for (int i = 0; i < int'(NC); i++) exp_vec[i] = 32'h7FFF_FFFF;
      do_run(1'b0, 1'b0, 4'd0, 32'h7FFF_FFFF);

      // LATENCY sweep on the 1 and 5 instances
      load('{0, 5, 3, 9, 1, 2, 7, 4, 8, 6});
      start_sw = 1'b1; tick(); start_sw = 1'b0;
      fv1 = -1; fv5 = -1; nx1 = 0; nx5 = 0; dn1 = -1; dn5 = -1; ok = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (v1 && fv1 < 0) fv1 = k;
         if (v5 && fv5 < 0) fv5 = k;
         if (v1) begin
            if (nx1 >= int'(NC) || i1 !== 4'(nx1) || d1 !== exp_vec[nx1]) ok = 1'b0;
            nx1++;
         end
         if (v5) begin
            if (nx5 >= int'(NC) || i5 !== 4'(nx5) || d5 !== exp_vec[nx5]) ok = 1'b0;
            nx5++;
         end
         if (done1 && dn1 < 0) dn1 = k;
         if (done5 && dn5 < 0) dn5 = k;
         tick();
      end
      check("l1_first_valid", 32'(fv1), 32'd1);
      check("l5_first_valid", 32'(fv5), 32'd5);
      check("l1_xfers", 32'(nx1), 32'd10);
      check("l5_xfers", 32'(nx5), 32'd10);
      check("sweep_data", 32'(ok), 32'd1);
      check("l1_done_edge", 32'(dn1), 32'd11);
      check("l5_done_edge", 32'(dn5), 32'd15);
      check("l5_class_id", 32'(ci5), 32'd3);
      check("l1_class_score", cs1, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
